// File: rtl/ed25519_keypair_serializer.sv
// Holds a finished Ed25519 key pair and streams it out one byte per valid/ready handshake.
// The secret-key copy is wiped as soon as the stream completes or the block is reset.
module ed25519_keypair_serializer #(
  parameter bit SEND_SECKEY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [255:0] pubkey_in,
  input  logic [511:0] seckey_in,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [7:0]   m_data,
  output logic         m_last,
  output logic         busy,
  output logic         load_dropped
);

  localparam int unsigned NumBytes = SEND_SECKEY ? 96 : 32;
  localparam logic [6:0]  LastIdx  = 7'(NumBytes - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e       state_q;
  logic [767:0] shadow_q;
  logic [6:0]   idx_q;
  logic         valid_q;
  logic         last_q;
  logic         dropped_q;
  logic [767:0] capture;

  // Secret half never enters the shadow when only the public key is to be sent.
  assign capture = SEND_SECKEY ? {seckey_in, pubkey_in} : {512'b0, pubkey_in};

  // Shadow shifts right one byte per handshake, so the current byte always sits at [7:0]
  // and the register is all-zero whenever the block is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            state_q  <= StSend;
            shadow_q <= capture;
            idx_q    <= '0;
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
          end
        end
        StSend: begin
          if (load) begin
            dropped_q <= 1'b1;
          end
          if (m_ready) begin
            if (idx_q == LastIdx) begin
              state_q  <= StIdle;
              shadow_q <= '0;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
            end else begin
              idx_q    <= idx_q + 7'd1;
              shadow_q <= {8'h00, shadow_q[767:8]};
              last_q   <= ((idx_q + 7'd1) == LastIdx);
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_valid      = valid_q;
  assign busy         = valid_q;
  assign m_data       = shadow_q[7:0];
  assign m_last       = last_q;
  assign load_dropped = dropped_q;

endmodule

// File: tb/tb_ed25519_keypair_serializer.sv
// Directed + randomized bench for ed25519_keypair_serializer; both SEND_SECKEY settings.
module tb_ed25519_keypair_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         load, m_ready;
  logic [255:0] pubkey;
  logic [511:0] seckey;
  logic         m_valid, m_last, busy, load_dropped;
  logic [7:0]   m_data;

  logic         load0, m_ready0;
  logic [255:0] pubkey0;
  logic [511:0] seckey0;
  logic         m_valid0, m_last0, busy0, load_dropped0;
  logic [7:0]   m_data0;

  int checks   = 0;
  int failures = 0;

  logic [255:0] ref_pub;
  logic [511:0] ref_sec;

  ed25519_keypair_serializer #(.SEND_SECKEY(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .pubkey_in    (pubkey),
    .seckey_in    (seckey),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .load_dropped (load_dropped)
  );

  ed25519_keypair_serializer #(.SEND_SECKEY(1'b0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .load         (load0),
    .pubkey_in    (pubkey0),
    .seckey_in    (seckey0),
    .m_ready      (m_ready0),
    .m_valid      (m_valid0),
    .m_data       (m_data0),
    .m_last       (m_last0),
    .busy         (busy0),
    .load_dropped (load_dropped0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: stream is pubkey bytes 0..31 followed by seckey bytes 0..63, LSB byte first.
  function automatic logic [7:0] exp_byte(input logic [255:0] p, input logic [511:0] s,
                                          input int k);
    if (k < 32) return p[8*k +: 8];
    return s[8*(k-32) +: 8];
  endfunction

  task automatic rand_keys(output logic [255:0] p, output logic [511:0] s);
    for (int i = 0; i < 8; i++)  p[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
  endtask

  // Called at a negedge; returns at the negedge after the capture edge E.
  task automatic load_keys(input logic [255:0] p, input logic [511:0] s);
    pubkey  = p;
    seckey  = s;
    ref_pub = p;
    ref_sec = s;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
  // stop_at >= 0 returns early once byte stop_at is on the bus (already checked).
  task automatic run_stream(input int rmode, input int drop_at, input bit drop_last,
                            input int stop_at);
    int          got;
    int          cyc;
    bit          rdy;
    bit          drop_pending;
    bit          drop_done;
    logic [255:0] jp;
    logic [511:0] js;
    got          = 0;
    cyc          = 0;
    drop_pending = 1'b0;
    drop_done    = 1'b0;
    while (got < 96 && cyc < 800) begin
      chk("valid", m_valid, 1);
      chk("busy", busy, 1);
      chk("data", m_data, exp_byte(ref_pub, ref_sec, got));
      chk("last", m_last, (got == 95));
      chk("dropped", load_dropped, drop_pending);
      if (got == stop_at) return;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready      = rdy;
      load         = 1'b0;
      drop_pending = 1'b0;
      if ((!drop_done && got == drop_at) || (drop_last && got == 95 && rdy)) begin
        rand_keys(jp, js);
        pubkey       = jp;
        seckey       = js;
        load         = 1'b1;
        drop_pending = 1'b1;
        if (got == drop_at) drop_done = 1'b1;
      end
      if (rdy) got++;
      cyc++;
      @(negedge clk);
    end
    load = 1'b0;
    chk("complete", got, 96);
    chk("idle_valid", m_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_data", m_data, 0);
    chk("idle_last", m_last, 0);
    chk("drop_final", load_dropped, drop_pending);
    chk("shadow_zero", (dut.shadow_q == '0), 1);
  endtask

  logic [255:0] p;
  logic [511:0] s;

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    m_ready  = 1'b0;
    pubkey   = '0;
    seckey   = '0;
    load0    = 1'b0;
    m_ready0 = 1'b0;
    pubkey0  = '0;
    seckey0  = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", load_dropped, 0);
    chk("rst_valid0", m_valid0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic directed stream.
    for (int k = 0; k < 32; k++) p[8*k +: 8] = 8'(k);
    for (int k = 0; k < 64; k++) s[8*k +: 8] = 8'(8'h40 + k);
    load_keys(p, s);
    run_stream(0, -1, 1'b0, -1);
    @(negedge clk);

    // Backpressure with the same keys.
    load_keys(p, s);
    run_stream(1, -1, 1'b0, -1);
    @(negedge clk);

    // Dropped loads at byte 10 and in the final-handshake cycle.
    rand_keys(p, s);
    load_keys(p, s);
    run_stream(0, 10, 1'b1, -1);
    @(negedge clk);
    chk("drop_once", load_dropped, 0);
    chk("drop_nocap", m_valid, 0);

    // Reset in the middle of byte 40.
    rand_keys(p, s);
    load_keys(p, s);
    run_stream(0, -1, 1'b0, 40);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", m_last, 0);
    @(negedge clk);
    rst     = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_resume", m_valid, 0);
    rand_keys(p, s);
    load_keys(p, s);
    run_stream(2, -1, 1'b0, -1);

    // Back-to-back: reload on F+1 straight after completion.
    rand_keys(p, s);
    load_keys(p, s);
    run_stream(2, -1, 1'b0, -1);
    rand_keys(p, s);
    load_keys(p, s);
    run_stream(0, 5, 1'b0, -1);

    // Pubkey-only instance.
    for (int k = 0; k < 32; k++) pubkey0[8*k +: 8] = 8'(8'hA0 + k);
    rand_keys(p, seckey0);
    m_ready0 = 1'b1;
    load0    = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    chk("pk_upper_zero", (dut0.shadow_q[767:256] == '0), 1);
    for (int k = 0; k < 32; k++) begin
      chk("pk_valid", m_valid0, 1);
      chk("pk_data", m_data0, 8'(8'hA0 + k));
      chk("pk_last", m_last0, (k == 31));
      @(negedge clk);
    end
    chk("pk_idle_valid", m_valid0, 0);
    chk("pk_idle_data", m_data0, 0);
    chk("pk_idle_busy", busy0, 0);
    chk("pk_no_drop", load_dropped0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ed25519_keypair_serializer.md
# ed25519_keypair_serializer

Downstream of the key-generation FSM top. Captures the finished key pair (256-bit compressed public key, 512-bit clamped expanded secret key) when the FSM's `done` pulses. Streams it out one byte per handshake over a valid/ready byte interface toward the host/UART link. Zeroizes its internal copy of the secret key once the stream finishes or is aborted.

## Interface
Parameters:
- `SEND_SECKEY`, default 1: 1 = stream pubkey then seckey (96 bytes); 0 = stream pubkey only (32 bytes).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `load`  in  1  one-cycle capture strobe; connected to the FSM `done`.
- `pubkey_in`  in  256  compressed public key; byte k = `pubkey_in[8k+7:8k]`.
- `seckey_in`  in  512  clamped expanded secret key; byte k = `seckey_in[8k+7:8k]`.
- `m_ready`  in  1  downstream ready.
- `m_valid`  out  1  `m_data` holds a valid byte.
- `m_data`  out  8  current byte; 0 whenever `m_valid` = 0.
- `m_last`  out  1  high with the final byte of the stream.
- `busy`  out  1  a stream is held or in progress.
- `load_dropped`  out  1  one-cycle pulse when a `load` is ignored.

## Operation
- N = 96 when `SEND_SECKEY` = 1, else N = 32.
- Byte order: pubkey bytes 0..31, then seckey bytes 0..63. Within each key, byte 0 (LSB byte) goes first.
- Storage is a 768-bit shadow register (bits 767:256 unused and tied 0 when `SEND_SECKEY` = 0) and a 7-bit byte counter `idx`.
- `m_data` = shadow byte `idx`, muxed or shifted.
- State machine:
  - IDLE: `busy` = 0, `m_valid` = 0. On `load` = 1, capture `{seckey_in, pubkey_in}` into shadow, set `idx` = 0, go to SEND.
  - SEND: `busy` = 1, `m_valid` = 1.
    - On `m_valid & m_ready` with `idx` < N-1: `idx` increments.
    - On `m_valid & m_ready` with `idx` = N-1: go to IDLE and clear shadow to all zeros in the same edge.
    - Without a handshake: `m_data`, `m_last`, and `idx` hold.
- `m_last` = (state = SEND) & (`idx` = N-1).
- `load` while state = SEND, including the final-handshake cycle: ignored, shadow unaffected, `load_dropped` = 1 for the following cycle.
- `load` is level-sampled. A `load` held high in IDLE is captured once; further high cycles while in SEND count as drops.
- Counter never wraps: `idx` only resets to 0 on capture or reset.
- Reset, including mid-stream: state = IDLE, `idx` = 0, shadow = 0, all outputs 0. No partial stream resumes after reset.

## Timing
- Reset values: `m_valid` = 0, `m_data` = 0, `m_last` = 0, `busy` = 0, `load_dropped` = 0.
- Capture latency: `load` sampled at edge E → `busy` = 1, `m_valid` = 1, `m_data` = `pubkey_in[7:0]` during cycle E+1.
- Throughput: 1 byte/cycle with `m_ready` held high. Full stream = N cycles of `m_valid`, the first at E+1 and the last at E+N.
- After the final handshake at edge F: `m_valid` = `busy` = 0 from F. A new `load` is accepted at edge F+1 or later.
- `m_valid` never drops while in SEND regardless of `m_ready`. `m_valid` does not depend combinationally on `m_ready`.
- `load_dropped` is registered: asserted the cycle after the ignored `load`.

## Test plan
- Basic stream, `SEND_SECKEY` = 1, `pubkey_in` byte k = k, `seckey_in` byte k = 0x40+k, `m_ready` = 1, single `load` pulse → 96 consecutive bytes 0x00..0x1F then 0x40..0x7F starting at E+1; `m_last` only on 0x7F; then `busy` = 0 and shadow reads 0.
- Backpressure: same data, `m_ready` = 1,0,0,1 repeating → byte sequence identical to the basic stream; `m_data` stable through every `m_ready` = 0 cycle; `m_valid` never deasserts before byte 95.
- Drop: second `load` with different keys at byte 10, and another in the final-handshake cycle → `load_dropped` pulses twice; output stream unchanged from the first capture.
- Reset mid-stream: assert `rst` during byte 40 → immediately `m_valid` = `m_data` = `busy` = 0. After release, a new `load` streams from byte 0 of the new keys.
- `SEND_SECKEY` = 0, pubkey bytes 0xA0+k → 32 bytes 0xA0..0xBF; `m_last` with 0xBF; no seckey bytes emitted.
- Back-to-back: `load` at F+1 after a completed stream → second stream begins at F+2 with correct byte 0.
